// File: rtl/axis_frame_tx_pkg.sv
// Shared types and defaults for the frame transmitter.
// The loop feature is enabled by defining AXIS_FRAME_TX_LOOP_EN.
package axis_frame_tx_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_DEPTH      = 16;
   localparam int DEF_ADDR_W     = $clog2(DEF_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
      return (len > depth) ? depth : len;
   endfunction

endpackage

// File: rtl/axis_tx_regfile.sv
// Sample buffer: synchronous write, combinational read, contents never reset.
// A read on the same edge as a write to that address returns the old value.
module axis_tx_regfile #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = 4
) (
   input  logic                         i_clk,
   input  logic                         i_wr_en,
   input  logic [ADDR_W-1:0]            i_wr_addr,
   input  logic signed [DATA_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_W-1:0]            i_rd_addr,
   output logic signed [DATA_WIDTH-1:0] o_rd_data
);

   logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axis_frame_tx.sv
// AXI4-Stream master that replays a buffered frame of samples on start.
// Defining AXIS_FRAME_TX_LOOP_EN adds loop_mode for gapless repeated frames.
module axis_frame_tx
   import axis_frame_tx_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_W     = DEF_ADDR_W
) (
`ifdef AXIS_FRAME_TX_LOOP_EN
   input  logic                         loop_mode,
`endif
   input  logic                         axi_clk,
   input  logic                         axi_reset_n,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic signed [DATA_WIDTH-1:0] wr_data,
   input  logic                         start,
   input  logic [ADDR_W:0]              frame_len,
   output logic                         busy,
   output logic                         done,
   output logic                         m_axis_valid,
   output logic signed [DATA_WIDTH-1:0] m_axis_data,
   output logic                         m_axis_last,
   input  logic                         m_axis_ready
);

   localparam logic [ADDR_W:0] LP_ONE = (ADDR_W+1)'(1);

   state_t                       r_state, w_state_nxt;
   logic [ADDR_W:0]              r_len, w_len_nxt;
   logic [ADDR_W:0]              r_ptr, w_ptr_nxt;
   logic                         r_valid, w_valid_nxt;
   logic                         r_last, w_last_nxt;
   logic                         r_done, w_done_nxt;
   logic signed [DATA_WIDTH-1:0] r_data, w_data_nxt;
   logic signed [DATA_WIDTH-1:0] w_rd_data;
   logic [ADDR_W-1:0]            w_rd_addr;
   logic [ADDR_W:0]              w_len_clamped;
   logic                         w_hs;
   logic                         w_loop;

`ifdef AXIS_FRAME_TX_LOOP_EN
   assign w_loop = loop_mode;
`else
   assign w_loop = 1'b0;
`endif

   assign w_len_clamped = (ADDR_W+1)'(clamp_len(32'(frame_len), DEPTH));
   assign w_hs          = r_valid & m_axis_ready;

   // The next load is mem[ptr] mid-frame; the first beat (and a loop wrap) reads mem[0].
   assign w_rd_addr = (r_state == SEND && !r_last) ? r_ptr[ADDR_W-1:0] : '0;

   axis_tx_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_regfile (
      .i_clk     (axi_clk),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_ptr_nxt   = r_ptr;
      w_valid_nxt = r_valid;
      w_last_nxt  = r_last;
      w_data_nxt  = r_data;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_len_nxt = w_len_clamped;
               if (w_len_clamped == '0) begin
                  w_state_nxt = DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_data_nxt  = w_rd_data;
                  w_last_nxt  = (w_len_clamped == LP_ONE);
                  w_valid_nxt = 1'b1;
                  w_ptr_nxt   = LP_ONE;
                  w_state_nxt = SEND;
               end
            end
         end
         SEND: begin
            if (w_hs) begin
               if (r_last) begin
                  w_done_nxt = 1'b1;
                  if (w_loop) begin
                     w_data_nxt = w_rd_data;
                     w_ptr_nxt  = LP_ONE;
                     w_last_nxt = (r_len == LP_ONE);
                  end else begin
                     w_valid_nxt = 1'b0;
                     w_last_nxt  = 1'b0;
                     w_state_nxt = DONE;
                  end
               end else begin
                  w_data_nxt = w_rd_data;
                  w_ptr_nxt  = r_ptr + LP_ONE;
                  w_last_nxt = (r_ptr == r_len - LP_ONE);
               end
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (!axi_reset_n) begin
         r_state <= IDLE;
         r_len   <= '0;
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_len   <= w_len_nxt;
         r_ptr   <= w_ptr_nxt;
         r_valid <= w_valid_nxt;
         r_last  <= w_last_nxt;
         r_done  <= w_done_nxt;
         r_data  <= w_data_nxt;
      end
   end

   assign busy         = (r_state != IDLE);
   assign done         = r_done;
   assign m_axis_valid = r_valid;
   assign m_axis_data  = r_data;
   assign m_axis_last  = r_last;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed self-checking bench for axis_frame_tx; the loop-mode section is
// compiled only when AXIS_FRAME_TX_LOOP_EN is defined.
module tb_axis_frame_tx;

   logic               axi_clk = 1'b0;
   logic               axi_reset_n;
   logic               wr_en;
   logic [3:0]         wr_addr;
   logic signed [15:0] wr_data;
   logic               start;
   logic [4:0]         frame_len;
   logic               busy, done, m_axis_valid, m_axis_last;
   logic signed [15:0] m_axis_data;
   logic               m_axis_ready;
`ifdef AXIS_FRAME_TX_LOOP_EN
   logic               loop_mode;
`endif

   int checks   = 0;
   int failures = 0;
   int mem_m [16];
   int got_d [$];
   int got_l [$];
   int hs_cyc, done_cyc;

   axis_frame_tx dut (
`ifdef AXIS_FRAME_TX_LOOP_EN
      .loop_mode    (loop_mode),
`endif
      .axi_clk      (axi_clk),
      .axi_reset_n  (axi_reset_n),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .start        (start),
      .frame_len    (frame_len),
      .busy         (busy),
      .done         (done),
      .m_axis_valid (m_axis_valid),
      .m_axis_data  (m_axis_data),
      .m_axis_last  (m_axis_last),
      .m_axis_ready (m_axis_ready)
   );

   always #5 axi_clk = ~axi_clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge axi_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = 4'(a);
      wr_data = 16'(d);
      tick();
      wr_en   = 1'b0;
      mem_m[a] = d;
   endtask

   // Starts a frame and gathers handshaken beats until done, checking hold-stability on stalls.
   task automatic run_frame(input int len_in, input int npat, input logic [15:0] pat);
      logic               prev_stall;
      logic signed [15:0] prev_d;
      logic               prev_l;
      got_d.delete();
      got_l.delete();
      hs_cyc = -1; done_cyc = -1;
      prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
      frame_len = 5'(len_in);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 80 && done_cyc < 0; c++) begin
         m_axis_ready = (c < npat) ? pat[c] : 1'b1;
         if (prev_stall) begin
            check("hold_valid", m_axis_valid, 1);
            check("hold_data", m_axis_data, prev_d);
            check("hold_last", m_axis_last, prev_l);
         end
         if (done) done_cyc = c;
         if (m_axis_valid && m_axis_ready) begin
            got_d.push_back(int'(m_axis_data));
            got_l.push_back(int'(m_axis_last));
            hs_cyc = c;
         end
         prev_stall = m_axis_valid && !m_axis_ready;
         prev_d     = m_axis_data;
         prev_l     = m_axis_last;
         tick();
      end
      m_axis_ready = 1'b1;
      if (done_cyc < 0) check("done_timeout", 0, 1);
   endtask

   task automatic verify_frame(input int n);
      check("beat_count", got_d.size(), n);
      for (int i = 0; i < n && i < got_d.size(); i++) begin
         check("beat_data", got_d[i], mem_m[i]);
         check("beat_last", got_l[i], (i == n - 1) ? 1 : 0);
      end
      if (n > 0) check("done_latency", done_cyc, hs_cyc + 1);
      check("idle_after", busy, 0);
   endtask

   initial begin
      axi_reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; frame_len = '0; m_axis_ready = 1'b1;
`ifdef AXIS_FRAME_TX_LOOP_EN
      loop_mode = 1'b0;
`endif
      tick(); tick();
      check("rst_valid", m_axis_valid, 0);
      check("rst_data", m_axis_data, 0);
      check("rst_last", m_axis_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      axi_reset_n = 1'b1;
      tick();

      // 1: back-to-back frame, first beat the cycle after start
      wr(0, 10); wr(1, -20); wr(2, 30); wr(3, -40);
      frame_len = 5'd4; m_axis_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_busy", busy, 1);
      for (int i = 0; i < 4; i++) begin
         check("t1_valid", m_axis_valid, 1);
         check("t1_data", m_axis_data, mem_m[i]);
         check("t1_last", m_axis_last, (i == 3) ? 1 : 0);
         check("t1_nodone", done, 0);
         tick();
      end
      check("t1_valid_off", m_axis_valid, 0);
      check("t1_done", done, 1);
      tick();
      check("t1_done_off", done, 0);
      check("t1_idle", busy, 0);

      // 2: backpressure pattern 1,0,0,1,0,1,1
      run_frame(4, 7, 16'h0069);
      verify_frame(4);

      // 3: zero length, then oversize length clamped to 16
      frame_len = 5'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check("t3_zero_valid", m_axis_valid, 0);
      check("t3_zero_done", done, 1);
      tick();
      check("t3_zero_done_off", done, 0);
      check("t3_zero_idle", busy, 0);
      for (int i = 4; i < 16; i++) wr(i, 100 * i - 777);
      run_frame(20, 0, 16'h0000);
      verify_frame(16);

      // 4: second start ignored, reset aborts mid-frame
      frame_len = 5'd4; m_axis_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_no_restart", m_axis_data, mem_m[2]);
      check("t4_busy", busy, 1);
      axi_reset_n = 1'b0;
      tick();
      axi_reset_n = 1'b1;
      check("t4_rst_valid", m_axis_valid, 0);
      check("t4_rst_busy", busy, 0);
      check("t4_rst_done", done, 0);
      check("t4_rst_data", m_axis_data, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_quiet_done", done, 0);
         check("t4_quiet_valid", m_axis_valid, 0);
      end
      run_frame(4, 0, 16'h0000);
      verify_frame(4);

      // 5: writes during SEND
      frame_len = 5'd4; m_axis_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check("t5_b0", m_axis_data, mem_m[0]);
      wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'sd555;
      tick();
      check("t5_b1_old", m_axis_data, mem_m[1]);
      wr_addr = 4'd3; wr_data = 16'sd99;
      tick();
      wr_en = 1'b0;
      check("t5_b2", m_axis_data, mem_m[2]);
      tick();
      check("t5_b3_new", m_axis_data, 99);
      check("t5_b3_last", m_axis_last, 1);
      tick();
      check("t5_done", done, 1);
      check("t5_valid_off", m_axis_valid, 0);
      mem_m[1] = 555; mem_m[3] = 99;
      tick();

`ifdef AXIS_FRAME_TX_LOOP_EN
      // 6: gapless looping, stop after the frame in which loop_mode drops
      loop_mode = 1'b1; frame_len = 5'd3; m_axis_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) loop_mode = 1'b0;
         check("t6_valid", m_axis_valid, 1);
         check("t6_data", m_axis_data, mem_m[k % 3]);
         check("t6_last", m_axis_last, (k % 3 == 2) ? 1 : 0);
         check("t6_done", done, (k == 3) ? 1 : 0);
         tick();
      end
      check("t6_end_valid", m_axis_valid, 0);
      check("t6_end_done", done, 1);
      tick();
      check("t6_idle", busy, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
